// File: rtl/iobus_tmr_pkg.sv
// iobus_tmr_pkg
// Shared definitions for the iobus_timer_bank peripheral: register offsets
// inside a channel slot, the IRQ_SUM offset, the per-channel slot stride,
// CSR bit positions, the packed CSR struct and a helper that renders the
// CSR struct as a 32-bit bus word.
// Optional feature macro: IOBUS_TMR_PRESCALE_EN (8-bit prescaler per channel).
package iobus_tmr_pkg;

    // Byte offsets of the registers inside one channel slot
    localparam logic [3:0]  REG_CSR     = 4'h0;
    localparam logic [3:0]  REG_RELOAD  = 4'h4;
    localparam logic [3:0]  REG_COUNT   = 4'h8;
    localparam logic [3:0]  REG_STATUS  = 4'hC;

    // Global register offset inside the 4 KiB window
    localparam logic [11:0] OFF_IRQ_SUM = 12'h100;

    // Channel c lives at BASE_ADDR + c*CH_STRIDE
    localparam int CH_STRIDE_LOG2 = 4;
    localparam int CH_STRIDE      = 1 << CH_STRIDE_LOG2;

    // CSR / STATUS bit positions
    localparam int CSR_EN_BIT      = 0;
    localparam int CSR_MODE_BIT    = 1;
    localparam int CSR_IE_BIT      = 2;
    localparam int CSR_PRESC_LSB   = 8;
    localparam int PRESC_W         = 8;
    localparam int STATUS_PEND_BIT = 0;

    typedef struct packed {
        logic [PRESC_W-1:0] presc;
        logic               ie;
        logic               mode;   // 0 = periodic, 1 = one-shot
        logic               en;
    } tmr_csr_t;

    function automatic logic [31:0] csr_to_word(input tmr_csr_t c);
        logic [31:0] w;
        w                                = '0;
        w[CSR_EN_BIT]                    = c.en;
        w[CSR_MODE_BIT]                  = c.mode;
        w[CSR_IE_BIT]                    = c.ie;
        w[CSR_PRESC_LSB +: PRESC_W]      = c.presc;
        return w;
    endfunction

endpackage

// File: rtl/tmr_channel.sv
// tmr_channel
// One timer channel: CSR, RELOAD, down-counter, pending flag and (when
// IOBUS_TMR_PRESCALE_EN is defined) an 8-bit prescaler.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   csr_wr         write strobe for CSR (bus data on wdata)
//   reload_wr      write strobe for RELOAD
//   status_wr      write strobe for STATUS (bit0 = 1 clears PEND)
//   wdata          bus write data
//   csr            current CSR contents
//   reload, count  current RELOAD and COUNT values
//   pend           registered pending flag
module tmr_channel
    import iobus_tmr_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             csr_wr,
    input  logic             reload_wr,
    input  logic             status_wr,
    input  logic [31:0]      wdata,
    output tmr_csr_t         csr,
    output logic [CNT_W-1:0] reload,
    output logic [CNT_W-1:0] count,
    output logic             pend
);

    tmr_csr_t         csr_q, csr_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pend_q, pend_d;
    logic             tick;

    // Only some write-data bits are meaningful to a channel
    logic             unused_wdata;
    assign unused_wdata = ^wdata;

`ifdef IOBUS_TMR_PRESCALE_EN
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
`endif

    always_comb begin
        csr_d    = csr_q;
        reload_d = reload_q;
        count_d  = count_q;
        pend_d   = pend_q;
        tick     = 1'b0;

`ifdef IOBUS_TMR_PRESCALE_EN
        presc_cnt_d = presc_cnt_q;
        // >= rather than == so a PRESC lowered mid-run cannot strand the counter
        if (csr_q.en) begin
            if (presc_cnt_q >= csr_q.presc) begin
                tick        = 1'b1;
                presc_cnt_d = '0;
            end else begin
                presc_cnt_d = presc_cnt_q + 8'd1;
            end
        end
`else
        tick = csr_q.en;
`endif

        // Clear first so that an expiry in the same cycle sets PEND again
        if (status_wr && wdata[STATUS_PEND_BIT]) begin
            pend_d = 1'b0;
        end

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                pend_d = 1'b1;
                if (csr_q.mode) begin
                    csr_d.en = 1'b0;
                end else begin
                    count_d = reload_q;
                end
            end
        end

        if (reload_wr) begin
            reload_d = wdata[CNT_W-1:0];
        end

        // A CSR write overrides whatever the expiry did to EN/MODE/IE
        if (csr_wr) begin
            csr_d.en   = wdata[CSR_EN_BIT];
            csr_d.mode = wdata[CSR_MODE_BIT];
            csr_d.ie   = wdata[CSR_IE_BIT];
`ifdef IOBUS_TMR_PRESCALE_EN
            csr_d.presc = wdata[CSR_PRESC_LSB +: PRESC_W];
`endif
            if (wdata[CSR_EN_BIT] && !csr_q.en) begin
                count_d = reload_q;
`ifdef IOBUS_TMR_PRESCALE_EN
                presc_cnt_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_q    <= '0;
            reload_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            csr_q    <= csr_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

`ifdef IOBUS_TMR_PRESCALE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end
`endif

    assign csr    = csr_q;
    assign reload = reload_q;
    assign count  = count_q;
    assign pend   = pend_q;

endmodule

// File: rtl/iobus_timer_bank.sv
// iobus_timer_bank
// Multi-channel programmable down-counter bank on the OTTER IOBUS.
// Channel c occupies BASE_ADDR + 16*c (CSR, RELOAD, COUNT, STATUS);
// IRQ_SUM at BASE_ADDR + 0x100 collects every channel's PEND.
// Optional feature macro: IOBUS_TMR_PRESCALE_EN adds an 8-bit prescaler
// per channel in CSR[15:8]; without it every cycle is a tick.
// Ports:
//   CLK, RESET_N   clock, asynchronous active-low reset
//   IOBUS_ADDR     bus address
//   IOBUS_OUT      bus write data
//   IOBUS_WR       single-cycle write strobe
//   IOBUS_RDATA    combinational read data, 0 when not hit
//   IOBUS_HIT      address decodes to a register of this block
//   INTR           OR over channels of PEND & IE
module iobus_timer_bank
    import iobus_tmr_pkg::*;
#(
    parameter int          N_CH      = 4,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h1100D000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_RDATA,
    output logic        IOBUS_HIT,
    output logic        INTR
);

    logic        in_win;
    logic        aligned;
    logic        ch_hit;
    logic        sum_hit;
    logic [11:0] off;
    logic [3:0]  ch_idx;
    logic [3:0]  reg_off;

    tmr_csr_t         ch_csr    [N_CH];
    logic [CNT_W-1:0] ch_reload [N_CH];
    logic [CNT_W-1:0] ch_count  [N_CH];
    logic [N_CH-1:0]  ch_pend;
    logic [N_CH-1:0]  ch_ie;
    logic [N_CH-1:0]  csr_wr;
    logic [N_CH-1:0]  reload_wr;
    logic [N_CH-1:0]  status_wr;
    logic [31:0]      irq_sum;

    assign in_win  = (IOBUS_ADDR[31:12] == BASE_ADDR[31:12]);
    assign off     = IOBUS_ADDR[11:0];
    assign aligned = (off[1:0] == 2'b00);
    assign ch_idx  = off[CH_STRIDE_LOG2 +: 4];
    assign reg_off = off[3:0];

    // Channel slots occupy [0, N_CH*CH_STRIDE) of the window
    assign ch_hit    = in_win && aligned && (off < 12'(N_CH * CH_STRIDE));
    assign sum_hit   = in_win && (off == OFF_IRQ_SUM);
    assign IOBUS_HIT = ch_hit || sum_hit;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic sel;
        assign sel          = IOBUS_WR && ch_hit && (ch_idx == 4'(g));
        assign csr_wr[g]    = sel && (reg_off == REG_CSR);
        assign reload_wr[g] = sel && (reg_off == REG_RELOAD);
        assign status_wr[g] = sel && (reg_off == REG_STATUS);
        assign ch_ie[g]     = ch_csr[g].ie;

        tmr_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (CLK),
            .rst_n     (RESET_N),
            .csr_wr    (csr_wr[g]),
            .reload_wr (reload_wr[g]),
            .status_wr (status_wr[g]),
            .wdata     (IOBUS_OUT),
            .csr       (ch_csr[g]),
            .reload    (ch_reload[g]),
            .count     (ch_count[g]),
            .pend      (ch_pend[g])
        );
    end

    assign irq_sum = 32'(ch_pend);
    assign INTR    = |(ch_pend & ch_ie);

    always_comb begin
        IOBUS_RDATA = '0;
        if (sum_hit) begin
            IOBUS_RDATA = irq_sum;
        end else if (ch_hit) begin
            for (int c = 0; c < N_CH; c++) begin
                if (ch_idx == 4'(c)) begin
                    case (reg_off)
                        REG_CSR:    IOBUS_RDATA = csr_to_word(ch_csr[c]);
                        REG_RELOAD: IOBUS_RDATA = 32'(ch_reload[c]);
                        REG_COUNT:  IOBUS_RDATA = 32'(ch_count[c]);
                        REG_STATUS: IOBUS_RDATA = {31'b0, ch_pend[c]};
                        default:    IOBUS_RDATA = '0;
                    endcase
                end
            end
        end
    end

endmodule
